// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Time-multiplexes a 3-digit packed BCD value onto a common-anode
// seven-segment display. The scan is one digit slot per DWELL cycles, with
// an optional all-off gap at the end of each slot against ghosting.
// Leading zeros can be suppressed. The input value is latched once per
// frame, so a counter rollover upstream never shows a torn reading.
// All outputs are registered and lag the slot counter by one cycle.

module seven_seg_scan #(
  parameter int CLK_HZ       = 100000000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] value,
  input  logic [2:0]  dp,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [2:0]  en_n,
  output logic        frame
);

  // Slot geometry. The counter is kept at least one bit wide so a
  // degenerate DWELL of 1 still elaborates.
  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;

  // Last count value of a slot, after which the counter wraps.
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);

  // First count value of the blank phase. This is one bit wider than the
  // counter so that BLANK_CYCLES=0, which gives DWELL itself, is representable.
  localparam logic [CW:0]   DRIVE_END = (CW+1)'(DWELL - BLANK_CYCLES);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [2:0] EN_OFF   = 3'b111;

  // Digit currently being scanned, rightmost first.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } digit_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one nibble. Non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  // Scan state
  logic [CW-1:0] cnt_r;
  digit_t        idx_r;

  // Frame snapshot
  logic [11:0]   snap_value_r;
  logic [2:0]    snap_dp_r;
  logic          snap_lz_r;

  // Next-state and datapath nets
  logic          take_snap_s;
  logic          cnt_wrap_s;
  logic [CW-1:0] cnt_next_s;
  digit_t        idx_next_s;
  logic [11:0]   cur_value_s;
  logic [2:0]    cur_dp_s;
  logic          cur_lz_s;
  logic [2:0]    sup_s;
  logic [3:0]    nib_s;
  logic          dp_bit_s;
  logic          sup_bit_s;
  logic [2:0]    sel_en_n_s;
  logic          drive_s;
  logic [6:0]    seg_next_s;
  logic          dp_n_next_s;
  logic [2:0]    en_n_next_s;

  // Slot counter wrap and digit advance.
  always_comb begin
    cnt_wrap_s  = 1'b0;
    cnt_next_s  = cnt_r;
    idx_next_s  = idx_r;
    take_snap_s = (cnt_r == {CW{1'b0}}) && (idx_r == DIG0);
    if (cnt_r == CNT_LAST) begin
      cnt_wrap_s = 1'b1;
      cnt_next_s = {CW{1'b0}};
    end else begin
      cnt_wrap_s = 1'b0;
      cnt_next_s = cnt_r + CW'(1);
    end
    if (cnt_wrap_s) begin
      case (idx_r)
        DIG0:    idx_next_s = DIG1;
        DIG1:    idx_next_s = DIG2;
        DIG2:    idx_next_s = DIG0;
        default: idx_next_s = DIG0;
      endcase
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Values in effect for this slot. On the snapshot edge the live inputs are
  // used, so the first digit of a frame already shows the new value.
  always_comb begin
    cur_value_s = snap_value_r;
    cur_dp_s    = snap_dp_r;
    cur_lz_s    = snap_lz_r;
    if (take_snap_s) begin
      cur_value_s = value;
      cur_dp_s    = dp;
      cur_lz_s    = blank_lz;
    end else begin
      cur_value_s = snap_value_r;
      cur_dp_s    = snap_dp_r;
      cur_lz_s    = snap_lz_r;
    end
  end

  // Leading-zero suppression chain. A digit is suppressed only if every
  // digit to its left is also suppressed. The rightmost digit is always shown.
  always_comb begin
    sup_s    = 3'b000;
    sup_s[2] = cur_lz_s && (cur_value_s[11:8] == 4'd0);
    sup_s[1] = sup_s[2] && (cur_value_s[7:4] == 4'd0);
    sup_s[0] = 1'b0;
  end

  // Per-digit selection of nibble, decimal point, suppression and enable.
  always_comb begin
    nib_s      = 4'd0;
    dp_bit_s   = 1'b0;
    sup_bit_s  = 1'b0;
    sel_en_n_s = EN_OFF;
    case (idx_r)
      DIG0: begin
        nib_s      = cur_value_s[3:0];
        dp_bit_s   = cur_dp_s[0];
        sup_bit_s  = sup_s[0];
        sel_en_n_s = 3'b110;
      end
      DIG1: begin
        nib_s      = cur_value_s[7:4];
        dp_bit_s   = cur_dp_s[1];
        sup_bit_s  = sup_s[1];
        sel_en_n_s = 3'b101;
      end
      DIG2: begin
        nib_s      = cur_value_s[11:8];
        dp_bit_s   = cur_dp_s[2];
        sup_bit_s  = sup_s[2];
        sel_en_n_s = 3'b011;
      end
      default: begin
        nib_s      = 4'd0;
        dp_bit_s   = 1'b0;
        sup_bit_s  = 1'b1;
        sel_en_n_s = EN_OFF;
      end
    endcase
  end

  // Output pattern for the next cycle: drive phase, suppressed digit, or blank.
  always_comb begin
    drive_s     = ({1'b0, cnt_r} < DRIVE_END);
    seg_next_s  = SEG_OFF;
    dp_n_next_s = 1'b1;
    en_n_next_s = EN_OFF;
    if (!drive_s) begin
      seg_next_s  = SEG_OFF;
      dp_n_next_s = 1'b1;
      en_n_next_s = EN_OFF;
    end else if (sup_bit_s && !dp_bit_s) begin
      // A suppressed digit with no decimal point stays dark.
      seg_next_s  = SEG_OFF;
      dp_n_next_s = 1'b1;
      en_n_next_s = EN_OFF;
    end else if (sup_bit_s) begin
      // A suppressed digit with a decimal point lights the dot only.
      seg_next_s  = SEG_OFF;
      dp_n_next_s = 1'b0;
      en_n_next_s = sel_en_n_s;
    end else begin
      seg_next_s  = seg_decode(nib_s);
      dp_n_next_s = ~dp_bit_s;
      en_n_next_s = sel_en_n_s;
    end
  end

  // Scan counter and digit index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= DIG0;
    end else begin
      cnt_r <= cnt_next_s;
      idx_r <= idx_next_s;
    end
  end

  // Once-per-frame snapshot of the display inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_value_r <= 12'h000;
      snap_dp_r    <= 3'b000;
      snap_lz_r    <= 1'b0;
    end else if (take_snap_s) begin
      snap_value_r <= value;
      snap_dp_r    <= dp;
      snap_lz_r    <= blank_lz;
    end else begin
      snap_value_r <= snap_value_r;
      snap_dp_r    <= snap_dp_r;
      snap_lz_r    <= snap_lz_r;
    end
  end

  // Registered display outputs and frame strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
      en_n  <= EN_OFF;
      frame <= 1'b0;
    end else begin
      seg_n <= seg_next_s;
      dp_n  <= dp_n_next_s;
      en_n  <= en_n_next_s;
      frame <= take_snap_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan with DWELL=10 and BLANK_CYCLES=2.
// The reference model works from the elapsed cycle count since reset
// release. The slot is (e/10)%3 and the position in the slot is e%10.
// A new frame starts whenever e%30==0. Expected segments come from a
// lookup table, and suppression follows the "all digits to the left are zero" rule.

module tb_seven_seg_scan;

  logic        clk;
  logic        reset;
  logic [11:0] value;
  logic [2:0]  dp;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [2:0]  en_n;
  logic        frame;

  seven_seg_scan #(
    .CLK_HZ      (100),
    .DIGIT_HZ    (10),
    .BLANK_CYCLES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .dp      (dp),
    .blank_lz(blank_lz),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .en_n    (en_n),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  int          e = 0;
  logic [11:0] m_val = 12'h000;
  logic [2:0]  m_dp  = 3'b000;
  logic        m_lz  = 1'b0;
  logic [6:0]  seg_tab [16];

  // Advance one clock, predicting the outputs registered at that edge, then compare on the falling edge.
  task automatic step(input string tag);
    logic [6:0] xs;
    logic       xd;
    logic [2:0] xe;
    logic       xf;
    int         slot;
    int         pos;
    logic [3:0] nib;
    logic       sup;
    xs = 7'h7F; xd = 1'b1; xe = 3'b111; xf = 1'b0;
    if (reset) begin
      e = 0;
    end else begin
      xf = (e % 30 == 0);
      if (xf) begin
        m_val = value; m_dp = dp; m_lz = blank_lz;
      end
      slot = (e / 10) % 3;
      pos  = e % 10;
      nib  = m_val[slot*4 +: 4];
      sup  = 1'b0;
      if (m_lz && slot > 0) begin
        sup = 1'b1;
        for (int j = slot; j < 3; j++)
          if (m_val[j*4 +: 4] != 4'd0) sup = 1'b0;
      end
      if (pos < 8 && !(sup && !m_dp[slot])) begin
        xe = ~(3'b001 << slot);
        xs = sup ? 7'h7F : seg_tab[nib];
        xd = ~m_dp[slot];
      end
      e++;
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    assert (seg_n === xs) else begin
      bad++; $error("FAIL %s seg_n observed=%b expected=%b (e=%0d)", tag, seg_n, xs, e);
    end
    total++;
    assert (dp_n === xd) else begin
      bad++; $error("FAIL %s dp_n observed=%b expected=%b (e=%0d)", tag, dp_n, xd, e);
    end
    total++;
    assert (en_n === xe) else begin
      bad++; $error("FAIL %s en_n observed=%b expected=%b (e=%0d)", tag, en_n, xe, e);
    end
    total++;
    assert (frame === xf) else begin
      bad++; $error("FAIL %s frame observed=%b expected=%b (e=%0d)", tag, frame, xf, e);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step("reset");
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rnd_nib();
    logic [3:0] r;
    r = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;

    reset = 1'b1; value = 12'h059; dp = 3'b000; blank_lz = 1'b0;

    // 1: reset held, then plain 0,5,9 scan
    do_reset(5);
    run(30, "basic_059");

    // 2: leading-zero suppression on and off
    value = 12'h005; blank_lz = 1'b1;
    run(30, "lz_on_005");
    blank_lz = 1'b0;
    run(30, "lz_off_005");

    // 3: input change mid-frame is deferred to the next frame
    value = 12'h059;
    run(15, "tear_pre");
    value = 12'h100;
    run(45, "tear_post");

    // 4: non-BCD nibble shows a dash
    value = 12'h0A3;
    run(30, "dash_0A3");

    // 5: all zero with suppression and a decimal point on digit2
    value = 12'h000; blank_lz = 1'b1; dp = 3'b100;
    run(30, "dp_sup_000");
    value = 12'h000; blank_lz = 1'b1; dp = 3'b010;
    run(30, "dp_sup_010");

    // 6: one-cycle reset in the middle of the digit1 drive phase
    value = 12'h321; blank_lz = 1'b0; dp = 3'b001;
    run(13, "pre_midreset");
    do_reset(1);
    run(30, "post_midreset");

    // Random inputs, changed at random points in the frame
    for (int f = 0; f < 25; f++) begin
      value    = {rnd_nib(), rnd_nib(), rnd_nib()};
      dp       = 3'($urandom_range(0, 7));
      blank_lz = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 40)), "random");
    end
    run(30, "random_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
